// File: rtl/kat_pkg.sv
// kat_pkg: shared types and helpers for the KAT sequencer.
//   kat_state_e : sequencer states
//   nb_w()      : width of a byte-count field for a given block width
//   byte_mask() : mask selecting the first nbytes bytes of a block (byte 0 = MSB)
package kat_pkg;

    localparam int unsigned MAX_BLK_BITS = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } kat_state_e;

    function automatic int unsigned nb_w(input int unsigned blk_size);
        return blk_size / 8 + 1;
    endfunction

    // Result is MAX_BLK_BITS wide; callers truncate to their block width.
    function automatic logic [MAX_BLK_BITS-1:0] byte_mask(input int unsigned nbytes,
                                                          input int unsigned blk_size);
        logic [MAX_BLK_BITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BLK_BITS / 8; i++) begin
            if ((i < nbytes) && (i < blk_size / 8)) begin
                m[(blk_size / 8 - 1 - i) * 8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/kat_masker.sv
// kat_masker: combinational Boolean share encoder.
//   i_value    : unmasked value (W bits)
//   i_rnd      : randomness for shares 1..D-1, share j at [(j-1)*W +: W]
//   o_shares_c : D shares, share j at [j*W +: W]; share 0 = value ^ all others
module kat_masker #(
    parameter int unsigned D = 2,
    parameter int unsigned W = 128
) (
    input  logic [W-1:0]       i_value,
    input  logic [(D-1)*W-1:0] i_rnd,
    output logic [D*W-1:0]     o_shares_c
);

    logic [W-1:0] w_acc;

    always_comb begin
        w_acc      = i_value;
        o_shares_c = '0;
        for (int unsigned j = 1; j < D; j++) begin
            o_shares_c[j*W +: W] = i_rnd[(j-1)*W +: W];
            w_acc                = w_acc ^ i_rnd[(j-1)*W +: W];
        end
        o_shares_c[W-1:0] = w_acc;
    end

endmodule

// File: rtl/kat_runner.sv
// kat_runner: known-answer-test sequencer for the masked AEAD cipher core.
// Latches the test vectors on run, pulses c_start, streams NBLK plaintext
// blocks, checks every returned ciphertext block and the final tag, and
// reports done/pass/timeout plus a saturating mismatch count.
// Ports:
//   clk, rst (sync, active-high), run
//   key/tweak1/tweak2/nonce/init_state/mask_rnd/msg/exp_ct/last_nbytes/exp_tag : vectors
//   c_*      : cipher-side streaming interface (outputs registered)
//   busy, done, pass, timeout, mismatches : status
// Option: define KAT_RANDOM_BACKPRESSURE_EN to drive c_ct_ready and gate
// c_pt_valid from a 16-bit LFSR (seed 16'hACE1, reloaded at start).
module kat_runner
    import kat_pkg::*;
#(
    parameter int unsigned D          = 2,
    parameter int unsigned KEY_SIZE   = 128,
    parameter int unsigned NONCE_SIZE = 128,
    parameter int unsigned BLK_SIZE   = 128,
    parameter int unsigned NBLK       = 4,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 run,
    input  logic [KEY_SIZE-1:0]                  key,
    input  logic [KEY_SIZE-1:0]                  tweak1,
    input  logic [KEY_SIZE-1:0]                  tweak2,
    input  logic [NONCE_SIZE-1:0]                nonce,
    input  logic [BLK_SIZE-1:0]                  init_state,
    input  logic [(D-1)*(KEY_SIZE+BLK_SIZE)-1:0] mask_rnd,
    input  logic [NBLK*BLK_SIZE-1:0]             msg,
    input  logic [NBLK*BLK_SIZE-1:0]             exp_ct,
    input  logic [nb_w(BLK_SIZE)-1:0]            last_nbytes,
    input  logic [BLK_SIZE-1:0]                  exp_tag,
    output logic                                 c_start,
    output logic [D*KEY_SIZE-1:0]                c_key,
    output logic [KEY_SIZE-1:0]                  c_tweak1,
    output logic [KEY_SIZE-1:0]                  c_tweak2,
    output logic [NONCE_SIZE-1:0]                c_nonce,
    output logic [BLK_SIZE-1:0]                  c_plaintext,
    output logic [D*BLK_SIZE-1:0]                c_init_state,
    output logic [nb_w(BLK_SIZE)-1:0]            c_pt_nbytes,
    output logic                                 c_pt_valid,
    output logic                                 c_ct_ready,
    output logic                                 c_ct_last,
    input  logic                                 c_pt_ready,
    input  logic [BLK_SIZE-1:0]                  c_ciphertext,
    input  logic [BLK_SIZE-1:0]                  c_tag,
    input  logic [nb_w(BLK_SIZE)-1:0]            c_ct_nbytes,
    input  logic                                 c_ct_valid,
    input  logic                                 c_finish,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 timeout,
    output logic [7:0]                           mismatches
);

    localparam int unsigned NB_W  = nb_w(BLK_SIZE);
    localparam int unsigned IDX_W = $clog2(NBLK + 1);
    localparam int unsigned CYC_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RK_W  = (D - 1) * KEY_SIZE;
    localparam int unsigned RI_W  = (D - 1) * BLK_SIZE;

    kat_state_e                r_state;
    logic [NBLK*BLK_SIZE-1:0]  r_msg;
    logic [NBLK*BLK_SIZE-1:0]  r_exp_ct;
    logic [BLK_SIZE-1:0]       r_exp_tag;
    logic [NB_W-1:0]           r_last_nbytes;
    logic [IDX_W-1:0]          r_pt_idx;
    logic [IDX_W-1:0]          r_ct_idx;
    logic [CYC_W-1:0]          r_cyc;
    logic [7:0]                r_mm;
    logic                      r_c_start, r_c_pt_valid, r_c_ct_ready, r_c_ct_last;
    logic [D*KEY_SIZE-1:0]     r_c_key;
    logic [KEY_SIZE-1:0]       r_c_tweak1, r_c_tweak2;
    logic [NONCE_SIZE-1:0]     r_c_nonce;
    logic [BLK_SIZE-1:0]       r_c_plaintext;
    logic [D*BLK_SIZE-1:0]     r_c_init_state;
    logic [NB_W-1:0]           r_c_pt_nbytes;
    logic                      r_busy, r_done, r_pass, r_timeout;

    logic [D*KEY_SIZE-1:0]     w_key_shares;
    logic [D*BLK_SIZE-1:0]     w_init_shares;
    logic                      w_pt_hs, w_ct_hs, w_ct_err, w_tag_eq, w_pt_load;
    logic                      w_pt_gate, w_ct_ready_nxt;
    logic [IDX_W-1:0]          w_pt_idx_nxt, w_pt_sel, w_ct_sel, w_ct_idx_nxt;
    logic [BLK_SIZE-1:0]       w_ct_mask, w_ct_exp;
    logic [7:0]                w_mm_nxt;

    // Share encoders: key randomness in the low part of mask_rnd, init_state above it.
    kat_masker #(.D(D), .W(KEY_SIZE)) u_key_masker (
        .i_value    (key),
        .i_rnd      (mask_rnd[RK_W-1:0]),
        .o_shares_c (w_key_shares)
    );

    kat_masker #(.D(D), .W(BLK_SIZE)) u_init_masker (
        .i_value    (init_state),
        .i_rnd      (mask_rnd[RK_W+RI_W-1:RK_W]),
        .o_shares_c (w_init_shares)
    );

`ifdef KAT_RANDOM_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced only while running.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_START)) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == ST_RUN) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_pt_gate      = r_lfsr[1];
    assign w_ct_ready_nxt = r_lfsr[0];
`else
    assign w_pt_gate      = 1'b1;
    assign w_ct_ready_nxt = 1'b1;
`endif

    assign w_pt_hs      = (r_state == ST_RUN) && r_c_pt_valid && c_pt_ready;
    assign w_ct_hs      = (r_state == ST_RUN) && r_c_ct_ready && c_ct_valid;
    assign w_pt_idx_nxt = r_pt_idx + IDX_W'(w_pt_hs);
    // A new block may be presented only when none is pending (valid never withdrawn).
    assign w_pt_load    = !r_c_pt_valid || w_pt_hs;
    assign w_pt_sel     = (w_pt_idx_nxt < IDX_W'(NBLK)) ? w_pt_idx_nxt : '0;
    assign w_ct_sel     = (r_ct_idx < IDX_W'(NBLK)) ? r_ct_idx : '0;
    assign w_ct_exp     = r_exp_ct[32'(w_ct_sel) * BLK_SIZE +: BLK_SIZE];
    assign w_ct_mask    = BLK_SIZE'(byte_mask(32'(c_ct_nbytes), BLK_SIZE));
    // Extra blocks beyond NBLK are errors regardless of content.
    assign w_ct_err     = (r_ct_idx >= IDX_W'(NBLK)) ||
                          (((c_ciphertext ^ w_ct_exp) & w_ct_mask) != '0);
    assign w_mm_nxt     = (w_ct_hs && w_ct_err && (r_mm != 8'hFF)) ? r_mm + 8'd1 : r_mm;
    assign w_ct_idx_nxt = (w_ct_hs && (r_ct_idx != IDX_W'(NBLK))) ? r_ct_idx + IDX_W'(1) : r_ct_idx;
    assign w_tag_eq     = (c_tag == r_exp_tag);

    // Sequencer: state, vector capture, feed/drain bookkeeping and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_msg          <= '0;
            r_exp_ct       <= '0;
            r_exp_tag      <= '0;
            r_last_nbytes  <= '0;
            r_pt_idx       <= '0;
            r_ct_idx       <= '0;
            r_cyc          <= '0;
            r_mm           <= '0;
            r_c_start      <= 1'b0;
            r_c_key        <= '0;
            r_c_tweak1     <= '0;
            r_c_tweak2     <= '0;
            r_c_nonce      <= '0;
            r_c_plaintext  <= '0;
            r_c_init_state <= '0;
            r_c_pt_nbytes  <= '0;
            r_c_pt_valid   <= 1'b0;
            r_c_ct_ready   <= 1'b0;
            r_c_ct_last    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_c_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        r_msg          <= msg;
                        r_exp_ct       <= exp_ct;
                        r_exp_tag      <= exp_tag;
                        r_last_nbytes  <= last_nbytes;
                        r_c_key        <= w_key_shares;
                        r_c_init_state <= w_init_shares;
                        r_c_tweak1     <= tweak1;
                        r_c_tweak2     <= tweak2;
                        r_c_nonce      <= nonce;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_state        <= ST_START;
                    end
                end
                ST_START: begin
                    r_c_start    <= 1'b1;
                    r_pt_idx     <= '0;
                    r_ct_idx     <= '0;
                    r_mm         <= '0;
                    r_pass       <= 1'b0;
                    r_timeout    <= 1'b0;
                    r_cyc        <= CYC_W'(1);
                    r_c_pt_valid <= 1'b0;
                    r_c_ct_ready <= 1'b1;
                    r_c_ct_last  <= 1'b0;
                    r_state      <= ST_RUN;
                end
                ST_RUN: begin
                    r_pt_idx     <= w_pt_idx_nxt;
                    r_ct_idx     <= w_ct_idx_nxt;
                    r_mm         <= w_mm_nxt;
                    r_cyc        <= r_cyc + CYC_W'(1);
                    r_c_ct_ready <= w_ct_ready_nxt;
                    if (w_pt_hs && (r_pt_idx == IDX_W'(NBLK - 1))) begin
                        r_c_ct_last <= 1'b1;
                    end
                    if (w_pt_load) begin
                        if ((w_pt_idx_nxt < IDX_W'(NBLK)) && w_pt_gate) begin
                            r_c_pt_valid  <= 1'b1;
                            r_c_plaintext <= r_msg[32'(w_pt_sel) * BLK_SIZE +: BLK_SIZE];
                            r_c_pt_nbytes <= (w_pt_sel == IDX_W'(NBLK - 1)) ?
                                             r_last_nbytes : NB_W'(BLK_SIZE / 8);
                        end else begin
                            r_c_pt_valid <= 1'b0;
                        end
                    end
                    // Finish wins over a coincident timeout; pass sees this cycle's block check.
                    if (c_finish || (r_cyc == CYC_W'(TIMEOUT))) begin
                        if (c_finish) begin
                            r_pass <= (w_mm_nxt == 8'd0) && w_tag_eq && (w_ct_idx_nxt == IDX_W'(NBLK));
                        end else begin
                            r_timeout <= 1'b1;
                            r_pass    <= 1'b0;
                        end
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_c_pt_valid <= 1'b0;
                        r_c_ct_ready <= 1'b0;
                        r_c_ct_last  <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign c_start      = r_c_start;
    assign c_key        = r_c_key;
    assign c_tweak1     = r_c_tweak1;
    assign c_tweak2     = r_c_tweak2;
    assign c_nonce      = r_c_nonce;
    assign c_plaintext  = r_c_plaintext;
    assign c_init_state = r_c_init_state;
    assign c_pt_nbytes  = r_c_pt_nbytes;
    assign c_pt_valid   = r_c_pt_valid;
    assign c_ct_ready   = r_c_ct_ready;
    assign c_ct_last    = r_c_ct_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign mismatches   = r_mm;

endmodule

// File: tb/tb_kat_runner.sv
// tb_kat_runner: directed bench for kat_runner with an inverting stub cipher
// (ciphertext = ~plaintext three cycles after accept, tag = nonce, finish one
// cycle after the last ciphertext).
module tb_kat_runner;

    localparam int unsigned D     = 2;
    localparam int unsigned KS    = 128;
    localparam int unsigned NS    = 128;
    localparam int unsigned BLK   = 128;
    localparam int unsigned NBLK  = 4;
    localparam int unsigned TMO   = 300;
    localparam int unsigned NBW   = BLK / 8 + 1;

    logic                          clk, rst, run;
    logic [KS-1:0]                 key, tweak1, tweak2;
    logic [NS-1:0]                 nonce;
    logic [BLK-1:0]                init_state, exp_tag;
    logic [(D-1)*(KS+BLK)-1:0]     mask_rnd;
    logic [NBLK*BLK-1:0]           msg, exp_ct;
    logic [NBW-1:0]                last_nbytes;
    logic                          c_start, c_pt_valid, c_ct_ready, c_ct_last;
    logic [D*KS-1:0]               c_key;
    logic [KS-1:0]                 c_tweak1, c_tweak2;
    logic [NS-1:0]                 c_nonce;
    logic [BLK-1:0]                c_plaintext;
    logic [D*BLK-1:0]              c_init_state;
    logic [NBW-1:0]                c_pt_nbytes;
    logic                          c_pt_ready, c_ct_valid, c_finish;
    logic [BLK-1:0]                c_ciphertext, c_tag;
    logic [NBW-1:0]                c_ct_nbytes;
    logic                          busy, done, pass, timeout;
    logic [7:0]                    mismatches;

    kat_runner #(
        .D(D), .KEY_SIZE(KS), .NONCE_SIZE(NS), .BLK_SIZE(BLK), .NBLK(NBLK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .key(key), .tweak1(tweak1), .tweak2(tweak2), .nonce(nonce),
        .init_state(init_state), .mask_rnd(mask_rnd), .msg(msg), .exp_ct(exp_ct),
        .last_nbytes(last_nbytes), .exp_tag(exp_tag),
        .c_start(c_start), .c_key(c_key), .c_tweak1(c_tweak1), .c_tweak2(c_tweak2),
        .c_nonce(c_nonce), .c_plaintext(c_plaintext), .c_init_state(c_init_state),
        .c_pt_nbytes(c_pt_nbytes), .c_pt_valid(c_pt_valid), .c_ct_ready(c_ct_ready),
        .c_ct_last(c_ct_last), .c_pt_ready(c_pt_ready), .c_ciphertext(c_ciphertext),
        .c_tag(c_tag), .c_ct_nbytes(c_ct_nbytes), .c_ct_valid(c_ct_valid),
        .c_finish(c_finish), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .mismatches(mismatches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp, n_err;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub cipher state, updated once per negedge.
    int             tb_cyc, ct_cnt, fin_due, fin_cyc, start_cnt;
    bit             stall;
    logic           last_at_fin;
    int             q_due[$];
    logic [BLK-1:0] q_data[$];
    logic [NBW-1:0] q_nb[$];
    logic [NBW-1:0] pt_nb_log[$];

    initial begin
        tb_cyc = 0; ct_cnt = 0; fin_due = -1; fin_cyc = -10; start_cnt = 0; last_at_fin = 1'b0;
        c_pt_ready = 1'b0; c_ct_valid = 1'b0; c_finish = 1'b0;
        c_ciphertext = '0; c_ct_nbytes = '0; c_tag = '0;
        forever begin
            @(negedge clk);
            tb_cyc++;
            if (c_start) start_cnt++;
            c_tag = nonce;
            if (rst) begin
                q_due.delete(); q_data.delete(); q_nb.delete();
                ct_cnt = 0; fin_due = -1;
                c_ct_valid = 1'b0; c_finish = 1'b0; c_pt_ready = 1'b0;
            end else begin
                if (q_due.size() > 0 && q_due[0] <= tb_cyc) begin
                    c_ct_valid   = 1'b1;
                    c_ciphertext = q_data[0];
                    c_ct_nbytes  = q_nb[0];
                end else begin
                    c_ct_valid = 1'b0;
                end
                c_finish = (fin_due == tb_cyc);
                if (c_finish) begin
                    fin_cyc     = tb_cyc;
                    last_at_fin = c_ct_last;
                end
                c_pt_ready = !stall;
                // Handshakes below take effect at the coming posedge.
                if (c_pt_valid && c_pt_ready) begin
                    q_due.push_back(tb_cyc + 3);
                    q_data.push_back(c_plaintext ^ '1);
                    q_nb.push_back(c_pt_nbytes);
                    pt_nb_log.push_back(c_pt_nbytes);
                end
                if (c_ct_valid && c_ct_ready) begin
                    void'(q_due.pop_front()); void'(q_data.pop_front()); void'(q_nb.pop_front());
                    ct_cnt++;
                    if (ct_cnt == NBLK) fin_due = tb_cyc + 1;
                end
            end
        end
    end

    task automatic set_default();
        msg         = '0;
        exp_ct      = '1;
        last_nbytes = NBW'(BLK / 8);
        nonce       = 128'hea135685849431216bee303e087f8a46;
        exp_tag     = 128'hea135685849431216bee303e087f8a46;
        ct_cnt      = 0;
        pt_nb_log.delete();
    endtask

    task automatic do_run(input string tag);
        run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        chk({tag, "_start_lat1"}, 256'(c_start), 256'(0));
        @(negedge clk); #1;
        chk({tag, "_start_lat2"}, 256'(c_start), 256'(1));
        chk({tag, "_busy"}, 256'(busy), 256'(1));
    endtask

    task automatic wait_done(input string tag, input int budget, output int waited);
        waited = 0;
        while (!done && waited < budget) begin
            @(negedge clk); #1;
            waited++;
        end
        chk({tag, "_done"}, 256'(done), 256'(1));
    endtask

    int w;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; run = 1'b0; stall = 1'b0;
        key        = 128'h544480d81a2483237c795768a7444ec3;
        tweak1     = 128'h00112233445566778899aabbccddeeff;
        tweak2     = 128'hfedcba98765432100123456789abcdef;
        init_state = 128'h0123456789abcdef0f1e2d3c4b5a6978;
        for (int i = 0; i < 8; i++) mask_rnd[i*32 +: 32] = $urandom;
        set_default();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start",  256'(c_start),    256'(0));
        chk("rst_busy",   256'(busy),       256'(0));
        chk("rst_done",   256'(done),       256'(0));
        chk("rst_ptv",    256'(c_pt_valid), 256'(0));
        chk("rst_key",    256'(c_key),      256'(0));
        rst = 1'b0;
        @(negedge clk); #1;

        // Test 1: clean run, share encoding, finish->done latency.
        start_cnt = 0;
        do_run("t1");
        chk("t1_key_xor",   256'(c_key[127:0] ^ c_key[255:128]),
                            256'(128'h544480d81a2483237c795768a7444ec3));
        chk("t1_key_sh1",   256'(c_key[255:128]), 256'(mask_rnd[127:0]));
        chk("t1_init_xor",  256'(c_init_state[127:0] ^ c_init_state[255:128]),
                            256'(128'h0123456789abcdef0f1e2d3c4b5a6978));
        chk("t1_init_sh1",  256'(c_init_state[255:128]), 256'(mask_rnd[255:128]));
        wait_done("t1", 2000, w);
        chk("t1_fin_lat",   256'(tb_cyc - fin_cyc), 256'(1));
        chk("t1_pass",      256'(pass), 256'(1));
        chk("t1_mm",        256'(mismatches), 256'(0));
        chk("t1_tmo",       256'(timeout), 256'(0));
        chk("t1_ctlast",    256'(last_at_fin), 256'(1));
        chk("t1_starts",    256'(start_cnt), 256'(1));
        chk("t1_busy_end",  256'(busy), 256'(0));

        // Test 2: block 2 bit 0 of the expected ciphertext corrupted.
        set_default();
        exp_ct[2*BLK] = 1'b0;
        do_run("t2");
        wait_done("t2", 2000, w);
        chk("t2_pass", 256'(pass), 256'(0));
        chk("t2_mm",   256'(mismatches), 256'(1));

        // Test 3: 5-byte last block; bytes 5..15 of the expectation are don't-care.
        set_default();
        last_nbytes = NBW'(5);
        exp_ct[3*BLK +: BLK] = {40'hFF_FFFF_FFFF, 88'h0};
        do_run("t3");
        wait_done("t3", 2000, w);
        chk("t3_pass",   256'(pass), 256'(1));
        chk("t3_mm",     256'(mismatches), 256'(0));
        chk("t3_nblk",   256'(pt_nb_log.size()), 256'(4));
        if (pt_nb_log.size() == 4) begin
            chk("t3_nb_first", 256'(pt_nb_log[0]), 256'(16));
            chk("t3_nb_last",  256'(pt_nb_log[3]), 256'(5));
        end

        // Test 4: cipher never accepts -> timeout.
        set_default();
        stall = 1'b1;
        do_run("t4");
        wait_done("t4", TMO + 100, w);
        chk("t4_tmo",    256'(timeout), 256'(1));
        chk("t4_pass",   256'(pass), 256'(0));
        chk("t4_window", 256'((w >= int'(TMO) - 10) && (w <= int'(TMO) + 10)), 256'(1));
        stall = 1'b0;

        // Test 5: reset mid-run, then a clean test.
        set_default();
        do_run("t5a");
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t5_rst_busy", 256'(busy), 256'(0));
        chk("t5_rst_done", 256'(done), 256'(0));
        chk("t5_rst_ptv",  256'(c_pt_valid), 256'(0));
        chk("t5_rst_key",  256'(c_key), 256'(0));
        start_cnt = 0;
        set_default();
        do_run("t5b");
        wait_done("t5b", 2000, w);
        chk("t5_pass",   256'(pass), 256'(1));
        chk("t5_starts", 256'(start_cnt), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kat_runner.md
# kat_runner

Synthesizable known-answer-test (KAT) sequencer for the masked AEAD cipher core. It drives the cipher's streaming interface (start, masked key and init state, plaintext blocks with valid/ready and byte counts) and checks every ciphertext block and the final tag against expected vectors. It reports pass/fail, mismatch count and timeout. It replaces hand-written stimulus sequences and can run on silicon or FPGA as a built-in self-test.

## Interface
Parameters:
- D, 2: number of Boolean shares.
- KEY_SIZE, 128: key/tweak width.
- NONCE_SIZE, 128: nonce width.
- BLK_SIZE, 128: block width, a multiple of 8.
- NBLK, 4: message blocks per run, ≥1.
- TIMEOUT, 65535: maximum cycles from start to finish.

Ports (clock is `clk`; reset is `rst`, synchronous and active-high, single clock domain):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  one-cycle request to start a test
- key, tweak1, tweak2  in  KEY_SIZE  unmasked vectors
- nonce  in  NONCE_SIZE
- init_state  in  BLK_SIZE  unmasked
- mask_rnd  in  (D-1)*(KEY_SIZE+BLK_SIZE)  share randomness
- msg, exp_ct  in  NBLK*BLK_SIZE  block i at bits [i*BLK_SIZE +: BLK_SIZE]
- last_nbytes  in  NB_W  valid bytes in last block, 1..BLK_SIZE/8
- exp_tag  in  BLK_SIZE
- cipher-side outputs: c_start 1, c_key D*KEY_SIZE, c_tweak1/c_tweak2 KEY_SIZE, c_nonce NONCE_SIZE, c_plaintext BLK_SIZE, c_init_state D*BLK_SIZE, c_pt_nbytes NB_W, c_pt_valid 1, c_ct_ready 1, c_ct_last 1
- cipher-side inputs: c_pt_ready 1, c_ciphertext BLK_SIZE, c_tag BLK_SIZE, c_ct_nbytes NB_W, c_ct_valid 1, c_finish 1
- busy, done, pass, timeout  out  1
- mismatches  out  8  saturating count

NB_W = BLK_SIZE/8 + 1.

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: on `run`, register all vectors, go to START. `run` is ignored in START and RUN.
- START: c_start=1 for exactly one cycle. Clear counters, pass, timeout and mismatches. Go to RUN.
- RUN feed side:
  - c_pt_valid=1 while pt_idx<NBLK.
  - c_plaintext = msg[pt_idx].
  - c_pt_nbytes = BLK_SIZE/8, except for the last block, where it is last_nbytes.
  - pt_idx increments on c_pt_valid & c_pt_ready.
  - c_ct_last rises the cycle after the last plaintext handshake and stays high until DONE.
- RUN drain side, concurrent with feed:
  - c_ct_ready=1.
  - On c_ct_valid & c_ct_ready, compare the first c_ct_nbytes bytes of c_ciphertext with exp_ct[ct_idx]. Byte 0 is bits [BLK_SIZE-1 -: 8].
  - Increment mismatches on inequality, then increment ct_idx.
  - Blocks arriving with ct_idx ≥ NBLK each count as one mismatch.
- c_finish in RUN: compare c_tag with exp_tag and go to DONE. pass = (mismatches==0) & tag equal & (ct_idx==NBLK).
- Timeout: cycle counter starts in START. Reaching TIMEOUT in RUN sets timeout=1, pass=0 and goes to DONE.
- DONE: done=1, results held. `run` starts a new test (DONE→START).
- Masking:
  - c_key share j≥1 comes from mask_rnd.
  - Share 0 = key XOR all other shares. c_init_state is built the same way.
  - Share j occupies bits [j*W +: W].
- mismatches saturates at 255.

## Timing
- Reset: every output is 0, state is IDLE. A reset mid-run aborts immediately; no partial result is reported.
- Latency: run→c_start is 2 cycles; c_finish→done is 1 cycle.
- busy=1 in START and RUN.
- Cipher-side outputs are registered. c_plaintext and c_pt_nbytes stay stable while c_pt_valid & !c_pt_ready.
- A ciphertext handshake and c_finish in the same cycle: the block is checked before pass is computed.
- c_finish outside RUN is ignored.

## Configuration
- KAT_RANDOM_BACKPRESSURE_EN:
  - Defined: a 16-bit LFSR (seed 16'hACE1, reloaded in START) drives c_ct_ready = lfsr[0] and gates c_pt_valid with lfsr[1]. c_pt_valid is never withdrawn once raised before its handshake. This exercises stalls and gaps.
  - Undefined: c_ct_ready stays high and c_pt_valid is never gated.

## Structure
- Package kat_pkg:
  - state enum
  - NB_W function
  - byte-mask function nbytes→BLK_SIZE mask
- Sub-module kat_masker, parameter D and W: combinational share encoder (value, randomness → D shares). Instantiated twice (key, init_state).

## Test plan
Bench stub cipher: ciphertext = plaintext ^ {BLK_SIZE{1'b1}}, 3 cycles after accept; tag = nonce; finish 1 cycle after the last ciphertext.
- NBLK=4, msg=0, exp_ct all-ones, nonce=128'hea135685849431216bee303e087f8a46, exp_tag=nonce → done, pass=1, mismatches=0.
- Corrupt exp_ct block 2 bit 0 → pass=0, mismatches=1.
- last_nbytes=5, last exp_ct differs only in bytes 5..15 → pass=1.
- Stub holds c_pt_ready=0 → timeout=1 after TIMEOUT cycles, pass=0.
- rst during RUN, then run → clean new test, c_start once, pass=1.
- Shares: XOR of c_key shares = 128'h544480d81a2483237c795768a7444ec3 for random mask_rnd.
